// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the reciprocal frequency measurement path.
package freq_meas_pkg;

    localparam int CLK_HZ_DEF = 50_000_000;
    localparam int CNT_W_DEF  = 26;

    // CLK_HZ fits in 26 bits, so CLK_HZ*N needs CNT_W+26 bits to stay exact.
    localparam int PROD_W = CNT_W_DEF + 26;

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        WAIT_FALL,
        SETTLE,
        DIV,
        DONE
    } state_t;

    function automatic int prod_width(input int cnt_w);
        return cnt_w + 26;
    endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Measurement request/result and counter gate signals of freq_gate_ctrl.
interface freq_gate_ctrl_if #(
    parameter int CNT_W = 26,
    parameter int Q_W   = 32
);
    logic             start;
    logic [31:0]      gate_len;
    logic             gate;
    logic             gate_out;
    logic [CNT_W-1:0] M;
    logic [CNT_W-1:0] N;
    logic             busy;
    logic [Q_W-1:0]   freq;
    logic             freq_valid;
    logic             err;

    // master is the controller; slave is the counter/requester side
    modport master (
        input  start, gate_len, gate_out, M, N,
        output gate, busy, freq, freq_valid, err
    );

    modport slave (
        output start, gate_len, gate_out, M, N,
        input  gate, busy, freq, freq_valid, err
    );
endinterface

// File: rtl/freq_gate_ctrl_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, MSB first.
module seq_divider #(
    parameter int DIVIDEND_W = 52,
    parameter int DIVISOR_W  = 26
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  done
);
    localparam int CNT_BITS = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] r_quo;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_div;
    logic [CNT_BITS-1:0]   r_cnt;
    logic                  r_done;
    logic [DIVISOR_W:0]    w_shift;
    logic [DIVISOR_W-1:0]  w_diff;
    logic                  w_fits;

    // Trial subtraction; remainder stays below divisor so DIVISOR_W bits hold it
    always_comb begin
        w_shift = {r_rem, r_quo[DIVIDEND_W-1]};
        w_fits  = (w_shift >= {1'b0, r_div});
        w_diff  = w_shift[DIVISOR_W-1:0] - r_div;
    end

    // Load operands on go, then shift the dividend out while quotient bits shift in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (go) begin
                r_quo <= dividend;
                r_rem <= '0;
                r_div <= divisor;
                r_cnt <= CNT_BITS'(DIVIDEND_W);
            end else if (r_cnt != '0) begin
                r_quo <= {r_quo[DIVIDEND_W-2:0], w_fits};
                r_rem <= w_fits ? w_diff : w_shift[DIVISOR_W-1:0];
                r_cnt <= r_cnt - CNT_BITS'(1);
                if (r_cnt == CNT_BITS'(1)) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient = r_quo;
    assign done     = r_done;
endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-window controller and result divider for the reciprocal frequency counter.
module freq_gate_ctrl
    import freq_meas_pkg::*;
#(
    parameter int CLK_HZ  = CLK_HZ_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int Q_W     = 32,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    freq_gate_ctrl_if.master bus
);
    localparam int             PW    = prod_width(CNT_W);
    localparam int             TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0]  CLK_K = PW'(CLK_HZ);

    state_t            r_state;
    state_t            w_next;
    logic              r_go_meta;
    logic              r_go_s;
    logic [31:0]       r_len_cnt;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_seen_hi;
    logic [2:0]        r_set_cnt;
    logic              r_gate;
    logic [Q_W-1:0]    r_freq;
    logic              r_err;
    logic              r_fv;
    logic              w_tmo_exp;
    logic              w_div_go;
    logic              w_div_done;
    logic              w_fin;
    logic              w_fin_err;
    logic [PW-1:0]     w_dividend;
    logic [PW-1:0]     w_quot;

    // Results above the output range clamp to all ones instead of wrapping
    function automatic logic [Q_W-1:0] sat_q(input logic [PW-1:0] q);
        if (|q[PW-1:Q_W]) begin
            return '1;
        end
        return q[Q_W-1:0];
    endfunction

    assign w_dividend = CLK_K * {{(PW-CNT_W){1'b0}}, bus.N};

    seq_divider #(
        .DIVIDEND_W (PW),
        .DIVISOR_W  (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (w_div_go),
        .dividend (w_dividend),
        .divisor  (bus.M),
        .quotient (w_quot),
        .done     (w_div_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the divider launch and result strobes
    always_comb begin
        w_next    = r_state;
        w_div_go  = 1'b0;
        w_fin     = 1'b0;
        w_fin_err = 1'b0;
        w_tmo_exp = (r_tmo == TMO_W'(TIMEOUT - 1));
        case (r_state)
            IDLE: begin
                if (bus.start) w_next = GATE;
            end
            GATE: begin
                if (r_len_cnt == 32'd1) begin
                    w_next = WAIT_FALL;
                end else if (w_tmo_exp && !r_seen_hi && !r_go_s) begin
                    // counter never answered the rising gate
                    w_next    = DONE;
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            WAIT_FALL: begin
                if (r_seen_hi && !r_go_s) begin
                    w_next = SETTLE;
                end else if (w_tmo_exp) begin
                    w_next    = DONE;
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            SETTLE: begin
                if (r_set_cnt == 3'd3) begin
                    if (bus.M == '0) begin
                        w_next    = DONE;
                        w_fin     = 1'b1;
                        w_fin_err = 1'b1;
                    end else begin
                        w_next   = DIV;
                        w_div_go = 1'b1;
                    end
                end
            end
            DIV: begin
                if (w_div_done) begin
                    w_next = DONE;
                    w_fin  = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Synchroniser, gate/timeout/settle counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_go_meta <= 1'b0;
            r_go_s    <= 1'b0;
            r_len_cnt <= '0;
            r_tmo     <= '0;
            r_seen_hi <= 1'b0;
            r_set_cnt <= '0;
            r_gate    <= 1'b0;
            r_freq    <= '0;
            r_err     <= 1'b0;
            r_fv      <= 1'b0;
        end else begin
            r_go_meta <= bus.gate_out;
            r_go_s    <= r_go_meta;

            if (r_state == IDLE && bus.start) begin
                r_len_cnt <= (bus.gate_len == 32'd0) ? 32'd1 : bus.gate_len;
            end else if (r_state == GATE) begin
                r_len_cnt <= r_len_cnt - 32'd1;
            end

            // restarting on every state change covers both the rise and fall windows
            if (w_next != r_state) begin
                r_tmo <= '0;
            end else if (r_state == GATE || r_state == WAIT_FALL) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end

            if (r_state == IDLE) begin
                r_seen_hi <= 1'b0;
            end else if ((r_state == GATE || r_state == WAIT_FALL) && r_go_s) begin
                r_seen_hi <= 1'b1;
            end

            r_set_cnt <= (r_state == SETTLE) ? r_set_cnt + 3'd1 : 3'd0;
            r_gate    <= (w_next == GATE);
            r_fv      <= w_fin;
            if (w_fin) begin
                r_err  <= w_fin_err;
                r_freq <= w_fin_err ? '0 : sat_q(w_quot);
            end
        end
    end

    assign bus.gate       = r_gate;
    assign bus.busy       = (r_state != IDLE);
    assign bus.freq       = r_freq;
    assign bus.freq_valid = r_fv;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl with a behavioural counter model.
module tb_freq_gate_ctrl;
    import freq_meas_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    freq_gate_ctrl_if #(.CNT_W(26), .Q_W(32)) bus ();

    freq_gate_ctrl #(
        .CLK_HZ  (50_000_000),
        .CNT_W   (26),
        .Q_W     (32),
        .TIMEOUT (200)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gate_hi_total = 0;
    int t_fall = 0;
    logic [25:0] m_val;
    logic [25:0] n_val;
    bit sig_dead;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.gate === 1'b1) gate_hi_total <= gate_hi_total + 1;

    // Counter model: gate_out follows gate a few cycles late, M/N update one cycle after its fall
    initial begin
        bus.gate_out = 1'b0;
        bus.M = '0;
        bus.N = '0;
        forever begin
            @(posedge bus.gate);
            if (!sig_dead) begin
                repeat (3) @(negedge clk);
                bus.gate_out = 1'b1;
                wait (bus.gate == 1'b0);
                repeat (3) @(negedge clk);
                bus.gate_out = 1'b0;
                t_fall = cyc;
                @(negedge clk);
                bus.M = m_val;
                bus.N = n_val;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [31:0] len);
        @(negedge clk);
        bus.gate_len = len;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_fv(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.freq_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic measure(input logic [31:0] len, input logic [25:0] m, input logic [25:0] n,
                           output bit seen);
        m_val = m;
        n_val = n;
        do_start(len);
        wait_fv(int'(len) + 400, seen);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.gate !== 1'b0) begin errors++; $display("FAIL reset_gate: got %b want 0", bus.gate); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.freq !== 32'd0) begin errors++; $display("FAIL reset_freq: got %0d want 0", bus.freq); end
        checks++; if (bus.freq_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b want 0", bus.freq_valid); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.gate !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b gate %b want 0 0", bus.busy, bus.gate); end
    endtask

    task automatic test_basic();
        bit seen;
        int g0;
        g0 = gate_hi_total;
        // 1000-clk window at a 20-clk sig period: M=1000, N=50
        measure(1000, 26'd1000, 26'd50, seen);
        checks++; if (!seen) begin errors++; $display("FAIL basic_fv: no freq_valid within budget"); end
        checks++; if (gate_hi_total - g0 !== 1000) begin errors++; $display("FAIL basic_gate_len: got %0d cycles want 1000", gate_hi_total - g0); end
        checks++; if (bus.freq !== 32'd2_500_000) begin errors++; $display("FAIL basic_freq: got %0d want 2500000", bus.freq); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", bus.err); end
        // 2 synchroniser cycles plus 58 from the go_s fall
        checks++; if (cyc - t_fall !== 60) begin errors++; $display("FAIL basic_latency: got %0d want 60", cyc - t_fall); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_fv: got %b want 1", bus.busy); end
        @(negedge clk);
        checks++; if (bus.freq_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_pulse: fv %b busy %b want 0 0", bus.freq_valid, bus.busy); end
        checks++; if (bus.freq !== 32'd2_500_000) begin errors++; $display("FAIL basic_hold: got %0d want 2500000", bus.freq); end
    endtask

    task automatic test_trunc();
        bit seen;
        measure(50, 26'd3, 26'd7, seen);
        checks++; if (!seen) begin errors++; $display("FAIL trunc_fv: no freq_valid within budget"); end
        checks++; if (bus.freq !== 32'd116_666_666 || bus.err !== 1'b0) begin errors++; $display("FAIL trunc_freq: got %0d err %b want 116666666 err 0", bus.freq, bus.err); end
    endtask

    task automatic test_saturate();
        bit seen;
        measure(50, 26'd1, 26'd100, seen);
        checks++; if (!seen) begin errors++; $display("FAIL sat_fv: no freq_valid within budget"); end
        checks++; if (bus.freq !== 32'hFFFF_FFFF || bus.err !== 1'b0) begin errors++; $display("FAIL sat_freq: got %h err %b want ffffffff err 0", bus.freq, bus.err); end
    endtask

    task automatic test_gate_len_zero();
        bit seen;
        int g0;
        g0 = gate_hi_total;
        measure(0, 26'd10, 26'd1, seen);
        checks++; if (gate_hi_total - g0 !== 1) begin errors++; $display("FAIL len0_gate: got %0d cycles want 1", gate_hi_total - g0); end
        checks++; if (!seen || bus.freq !== 32'd5_000_000) begin errors++; $display("FAIL len0_freq: seen %b got %0d want 5000000", seen, bus.freq); end
    endtask

    task automatic test_timeout();
        bit seen;
        int t0;
        sig_dead = 1'b1;
        m_val = 26'd5;
        n_val = 26'd5;
        do_start(100);
        t0 = cyc;
        wait_fv(600, seen);
        checks++; if (!seen) begin errors++; $display("FAIL tmo_fv: no freq_valid within budget"); end
        checks++; if (cyc - t0 !== 300) begin errors++; $display("FAIL tmo_time: got %0d want 300", cyc - t0); end
        checks++; if (bus.err !== 1'b1 || bus.freq !== 32'd0) begin errors++; $display("FAIL tmo_result: err %b freq %0d want 1 0", bus.err, bus.freq); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b want 0", bus.busy); end
        sig_dead = 1'b0;
    endtask

    task automatic test_m_zero();
        bit seen;
        measure(40, 26'd0, 26'd5, seen);
        checks++; if (!seen) begin errors++; $display("FAIL mzero_fv: no freq_valid within budget"); end
        checks++; if (bus.err !== 1'b1 || bus.freq !== 32'd0) begin errors++; $display("FAIL mzero_result: err %b freq %0d want 1 0", bus.err, bus.freq); end
        // no 52-cycle divide: result lands right after the settle window
        checks++; if (cyc - t_fall !== 7) begin errors++; $display("FAIL mzero_latency: got %0d want 7", cyc - t_fall); end
    endtask

    task automatic test_ignore_start();
        int g0;
        int fv_cnt;
        logic [31:0] f_seen;
        g0 = gate_hi_total;
        fv_cnt = 0;
        f_seen = '0;
        m_val = 26'd400;
        n_val = 26'd9;
        do_start(300);
        repeat (50) @(negedge clk);
        do_start(5);
        repeat (299) @(negedge clk);
        do_start(5);
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (bus.freq_valid === 1'b1) begin
                fv_cnt++;
                f_seen = bus.freq;
            end
        end
        checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL ignore_count: got %0d want 1", fv_cnt); end
        checks++; if (gate_hi_total - g0 !== 300) begin errors++; $display("FAIL ignore_gate: got %0d cycles want 300", gate_hi_total - g0); end
        checks++; if (f_seen !== 32'd1_125_000) begin errors++; $display("FAIL ignore_freq: got %0d want 1125000", f_seen); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        measure(30, 26'd7, 26'd2, seen);
        checks++; if (!seen || bus.freq !== 32'd14_285_714) begin errors++; $display("FAIL b2b_first: seen %b got %0d want 14285714", seen, bus.freq); end
        @(negedge clk);
        m_val = 26'd40;
        n_val = 26'd3;
        bus.gate_len = 32'd20;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.gate !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: gate %b busy %b want 1 1", bus.gate, bus.busy); end
        wait_fv(500, seen);
        checks++; if (!seen || bus.freq !== 32'd3_750_000) begin errors++; $display("FAIL b2b_second: seen %b got %0d want 3750000", seen, bus.freq); end
    endtask

    task automatic test_reset_mid_div();
        bit seen;
        int fv_cnt;
        fv_cnt = 0;
        m_val = 26'd5;
        n_val = 26'd4;
        do_start(40);
        repeat (70) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.gate !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL arst_ctrl: gate %b busy %b want 0 0", bus.gate, bus.busy); end
        checks++; if (bus.freq !== 32'd0) begin errors++; $display("FAIL arst_freq: got %0d want 0", bus.freq); end
        checks++; if (bus.freq_valid !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL arst_flags: fv %b err %b want 0 0", bus.freq_valid, bus.err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.freq_valid === 1'b1) fv_cnt++;
        end
        checks++; if (fv_cnt !== 0) begin errors++; $display("FAIL arst_no_fv: got %0d pulses want 0", fv_cnt); end
        measure(40, 26'd5, 26'd4, seen);
        checks++; if (!seen || bus.freq !== 32'd40_000_000 || bus.err !== 1'b0) begin errors++; $display("FAIL arst_rerun: seen %b got %0d err %b want 40000000 err 0", seen, bus.freq, bus.err); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.gate_len = '0;
        sig_dead = 1'b0;
        m_val = '0;
        n_val = '0;
        test_reset();
        test_basic();
        test_trunc();
        test_saturate();
        test_gate_len_zero();
        test_timeout();
        test_m_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
